// File: rtl/seq_addsub_unit.sv
// seq_addsub_unit: digit-serial adder/subtractor.
// Operands are captured on accept and processed DIGIT bits per clock, LSB
// slice first, with the slice carry rippled through a register.
// Ops: 00/11 add, 01 two's-complement sub, 10 ones'-complement sub with
// end-around carry.
// Optional feature macro: SEQ_ADDSUB_EAC_EN. When it is defined, op 10 runs
// a second serial pass (EAC state) that folds the end-around carry back in.
// When it is undefined, op 10 is executed as op 01.
module seq_addsub_unit #(
   parameter int WIDTH = 8,
   parameter int DIGIT = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       op,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             busy
);

   localparam int N  = WIDTH / DIGIT;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

`ifdef SEQ_ADDSUB_EAC_EN
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, EAC = 2'd2, DONE = 2'd3} state_t;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd3} state_t;
`endif

   state_t            state, state_nxt;
   logic [WIDTH-1:0]  a_r, b_r, res_r, res_ins;
   logic              carry, cout_r, sub_r;
   logic [CW-1:0]     cnt;
   logic              last, in_eac;
   logic              is_sub_in, is_eac_in;
   logic [DIGIT-1:0]  add_x, add_y;
   logic [DIGIT:0]    sum;
`ifdef SEQ_ADDSUB_EAC_EN
   logic              eac_r;
`endif

   // Op decode on the input side; sub_r also drives the final borrow inversion.
`ifdef SEQ_ADDSUB_EAC_EN
   assign is_eac_in = (op == 2'b10);
   assign is_sub_in = (op == 2'b01);
   assign in_eac    = (state == EAC);
`else
   assign is_eac_in = 1'b0;
   assign is_sub_in = (op == 2'b01) || (op == 2'b10);
   assign in_eac    = 1'b0;
`endif

   assign last = (cnt == CW'(N - 1));

   // One shared slice adder: operand slices in RUN, partial result plus carry in EAC.
   assign add_x = in_eac ? res_r[DIGIT-1:0] : a_r[DIGIT-1:0];
   assign add_y = in_eac ? '0 : b_r[DIGIT-1:0];
   assign sum   = {1'b0, add_x} + {1'b0, add_y} + {{DIGIT{1'b0}}, carry};

   // New slice enters at the top of the result and the register shifts right,
   // so after N slices the LSB slice sits at bit 0.
   generate
      if (WIDTH == DIGIT) begin : g_one_slice
         assign res_ins = sum[DIGIT-1:0];
      end else begin : g_multi_slice
         assign res_ins = {sum[DIGIT-1:0], res_r[WIDTH-1:DIGIT]};
      end
   endgenerate

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: if (in_valid) state_nxt = RUN;
         RUN: begin
            if (last) begin
`ifdef SEQ_ADDSUB_EAC_EN
               state_nxt = eac_r ? EAC : DONE;
`else
               state_nxt = DONE;
`endif
            end
         end
`ifdef SEQ_ADDSUB_EAC_EN
         EAC:  if (last) state_nxt = DONE;
`endif
         DONE: if (out_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Operand capture, serial slice processing and result/carry registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_r    <= '0;
         b_r    <= '0;
         res_r  <= '0;
         carry  <= 1'b0;
         cout_r <= 1'b0;
         sub_r  <= 1'b0;
         cnt    <= '0;
`ifdef SEQ_ADDSUB_EAC_EN
         eac_r  <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_r   <= a;
                  // Subtraction is a + ~b; two's-complement adds 1 unless borrowing.
                  b_r   <= (is_sub_in || is_eac_in) ? ~b : b;
                  carry <= is_sub_in ? ~cin : (is_eac_in ? 1'b0 : cin);
                  sub_r <= is_sub_in;
                  cnt   <= '0;
`ifdef SEQ_ADDSUB_EAC_EN
                  eac_r <= is_eac_in;
`endif
               end
            end
            RUN: begin
               a_r   <= a_r >> DIGIT;
               b_r   <= b_r >> DIGIT;
               res_r <= res_ins;
               carry <= sum[DIGIT];
               cnt   <= last ? '0 : cnt + CW'(1);
               // Borrow is the inverted carry; add and EAC report the raw carry.
               if (last) cout_r <= sub_r ^ sum[DIGIT];
            end
`ifdef SEQ_ADDSUB_EAC_EN
            EAC: begin
               res_r <= res_ins;
               carry <= sum[DIGIT];
               cnt   <= last ? '0 : cnt + CW'(1);
            end
`endif
            default: ;
         endcase
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);
   assign result    = res_r;
   assign cout      = cout_r;

endmodule

// File: tb/tb_seq_addsub_unit.sv
// Bench for seq_addsub_unit (WIDTH=8, DIGIT=4). Define SEQ_ADDSUB_EAC_EN for
// both bench and RTL to exercise the end-around-carry build.
module tb_seq_addsub_unit;

   localparam int N = 2;

   typedef struct {
      logic [7:0] res;
      logic       c;
      int         lat;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] a = '0, b = '0;
   logic [1:0] op = '0;
   logic       cin = 1'b0;
   logic       out_valid;
   logic       out_ready = 1'b0;
   logic [7:0] result;
   logic       cout;
   logic       busy;

   int   n_chk = 0;
   int   n_fail = 0;
   exp_t sb[$];

   seq_addsub_unit #(.WIDTH(8), .DIGIT(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .op(op), .cin(cin), .out_valid(out_valid),
      .out_ready(out_ready), .result(result), .cout(cout), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t model(input logic [7:0] ta, input logic [7:0] tb_,
                                  input logic [1:0] top, input logic tc);
      exp_t       e;
      logic [8:0] s;
      e.lat = N;
      case (top)
         2'b01: begin
            e.res = ta - tb_ - {7'd0, tc};
            e.c   = ({1'b0, ta} < ({1'b0, tb_} + {8'd0, tc}));
         end
         2'b10: begin
`ifdef SEQ_ADDSUB_EAC_EN
            s     = {1'b0, ta} + {1'b0, ~tb_};
            e.c   = s[8];
            e.res = s[7:0] + {7'd0, s[8]};
            e.lat = 2 * N;
`else
            e.res = ta - tb_ - {7'd0, tc};
            e.c   = ({1'b0, ta} < ({1'b0, tb_} + {8'd0, tc}));
`endif
         end
         default: begin
            s     = {1'b0, ta} + {1'b0, tb_} + {8'd0, tc};
            e.res = s[7:0];
            e.c   = s[8];
         end
      endcase
      return e;
   endfunction

   // Issue one op, wait for its result, compare against the scoreboard,
   // optionally stall in DONE for 'hold' cycles, then hand it off.
   task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_,
                         input logic [1:0] top, input logic tc, input int hold);
      exp_t       e;
      int         lat;
      bit         got;
      logic [7:0] r0;
      logic       c0;
      sb.push_back(model(ta, tb_, top, tc));
      @(negedge clk);
      chk("in_ready_idle", in_ready, 1);
      a = ta; b = tb_; op = top; cin = tc; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      // Scramble inputs after accept; the captured values must be used.
      a = 8'($urandom); b = 8'($urandom); op = 2'($urandom); cin = 1'($urandom);
      lat = 0;
      got = 1'b0;
      while (!got && lat < 20) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
         if (out_valid) got = 1'b1;
      end
      e = sb.pop_front();
      if (!got) begin
         chk("timeout", 0, 1);
         return;
      end
      chk("result", result, e.res);
      chk("cout", cout, e.c);
      chk("latency", lat, e.lat);
      if (hold > 0) begin
         r0 = result;
         c0 = cout;
         repeat (hold) begin
            in_valid = 1'b1;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            @(negedge clk);
            chk("hold_valid", out_valid, 1);
            chk("hold_ready", in_ready, 0);
            chk("hold_result", result, r0);
            chk("hold_cout", cout, c0);
         end
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk("drain_valid", out_valid, 0);
      chk("drain_in_ready", in_ready, 1);
      chk("drain_busy", busy, 0);
   endtask

   initial begin
      int ov_cnt;
      #2;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_result", result, 0);
      chk("rst_cout", cout, 0);
      @(negedge clk);
      rst_n = 1'b1;

      run_op(8'hF0, 8'h1F, 2'b00, 1'b1, 0);
      run_op(8'h05, 8'h07, 2'b01, 1'b0, 0);
      run_op(8'h07, 8'h05, 2'b01, 1'b1, 0);
`ifdef SEQ_ADDSUB_EAC_EN
      run_op(8'h07, 8'h05, 2'b10, 1'b0, 0);
      run_op(8'h33, 8'h33, 2'b10, 1'b1, 0);
      run_op(8'h05, 8'h07, 2'b10, 1'b0, 0);
`else
      run_op(8'h05, 8'h07, 2'b10, 1'b0, 0);
`endif
      run_op(8'h3C, 8'hC4, 2'b11, 1'b1, 5);
      run_op(8'hFF, 8'hFF, 2'b01, 1'b1, 0);
      run_op(8'h00, 8'h00, 2'b01, 1'b1, 0);
      for (int i = 0; i < 24; i++)
         run_op(8'($urandom), 8'($urandom), 2'($urandom), 1'($urandom), 0);

      // Reset while RUN is in progress.
      @(negedge clk);
      a = 8'hAA; b = 8'h11; op = 2'b00; cin = 1'b0; in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(negedge clk);
      chk("run_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      chk("arst_busy", busy, 0);
      chk("arst_in_ready", in_ready, 1);
      chk("arst_out_valid", out_valid, 0);
      chk("arst_result", result, 0);
      @(negedge clk);
      rst_n = 1'b1;
      ov_cnt = 0;
      repeat (6) begin
         @(negedge clk);
         if (out_valid) ov_cnt++;
      end
      chk("no_stale_valid", ov_cnt, 0);
      run_op(8'h12, 8'h34, 2'b00, 1'b0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

endmodule
